pwm_audio_out: RTL

- Output stage directly downstream of the SID filter/volume block.
- Consumes its 8-bit unsigned post-volume sample stream (sample + sample_valid strobe) and produces a 1-bit PWM audio signal for an external RC low-pass.
- Decouples the sample rate from the PWM frame with a one-deep pending buffer. Loads a new duty only at frame boundaries, so there are no mid-frame glitches.
- Flags sample overrun.

---
 rtl/sid_audio_pkg.sv | 11 +
 rtl/pwm_lfsr16.sv | 20 ++
 rtl/pwm_audio_out.sv | 89 ++++++++
 3 files changed

// File: rtl/sid_audio_pkg.sv
// Shared constants for the SID audio output path: sample width and LFSR definition.
package sid_audio_pkg;
    localparam int          SAMPLE_W  = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/pwm_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle with step high.
module pwm_lfsr16
    import sid_audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] state
);
    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LFSR_SEED;
        else if (step)
            r_state <= lfsr_next(r_state);
    end

    assign state = r_state;
endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output with one-deep pending sample buffer, loaded only at frame wrap.
// Build option: define PWM_DITHER_EN to add LFSR dither to the low duty bits (CNT_W > 8).
module pwm_audio_out
    import sid_audio_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                enable,
    input  logic                overrun_clr,
    output logic                pwm_out,
    output logic                frame_start,
    output logic                overrun
);
    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_duty;
    logic [SAMPLE_W-1:0] r_pend;
    logic                r_pend_full;
    logic                r_pwm;
    logic                r_frame_start;
    logic                r_overrun;

    logic                w_wrap;
    logic                w_ovr_set;
    logic [CNT_W-1:0]    w_dither;
    logic [CNT_W-1:0]    w_duty_ext;

    assign w_wrap    = enable && (r_cnt == {CNT_W{1'b1}});
    // A sample coincident with wrap refills the slot being drained: not an overrun.
    assign w_ovr_set = sample_valid && r_pend_full && !w_wrap;

`ifdef PWM_DITHER_EN
    logic [15:0] w_lfsr;
    logic [15:0] w_lfsr_mask;

    pwm_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (w_wrap),
        .state (w_lfsr)
    );

    // Mask selects lfsr[CNT_W-9:0]; empty when CNT_W == 8.
    assign w_lfsr_mask = 16'((32'd1 << (CNT_W - 8)) - 32'd1);
    assign w_dither    = CNT_W'(w_lfsr & w_lfsr_mask);
`else
    assign w_dither    = '0;
`endif

    assign w_duty_ext = (CNT_W'(r_duty) << (CNT_W - 8)) | w_dither;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_duty        <= '0;
            r_pend        <= '0;
            r_pend_full   <= 1'b0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cnt         <= enable ? r_cnt + 1'b1 : '0;
            r_pwm         <= enable && (r_cnt < w_duty_ext);
            r_frame_start <= w_wrap;

            if (w_wrap && r_pend_full)
                r_duty <= r_pend;

            if (sample_valid) begin
                r_pend      <= sample_in;
                r_pend_full <= 1'b1;
            end else if (w_wrap) begin
                r_pend_full <= 1'b0;
            end

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_frame_start;
    assign overrun     = r_overrun;
endmodule
